// File: rtl/freq_div_pkg.sv
// freq_div_pkg: shared constants and helpers for the multi-channel
// clock divider.
//   DEF_DIV / DEF_HIGH : divisor and high time every channel holds after reset
//   calc_t / eff_t     : wide working types used by the saturation helper
//   saturate()         : maps a programmed (div, high) pair to its effective
//                        values: Peff = max(div,1), Heff = min(high,Peff)
package freq_div_pkg;

  localparam int DEF_DIV  = 4;
  localparam int DEF_HIGH = 2;

  // Wide enough for any practical counter width. Callers zero-extend into
  // this type and truncate back, so the helper stays width-independent.
  localparam int CALC_W = 64;

  typedef logic [CALC_W-1:0] calc_t;

  typedef struct packed {
    calc_t div;
    calc_t high;
  } eff_t;

  function automatic eff_t saturate(input calc_t div, input calc_t high);
    eff_t r;
    // A zero divisor behaves like 1: tick every cycle.
    r.div  = (div == '0) ? calc_t'(1) : div;
    // High time longer than the period means constantly high.
    r.high = (high > r.div) ? r.div : high;
    return r;
  endfunction

endpackage

// File: rtl/freq_div_chan.sv
// freq_div_chan: one divider channel.
//   clk_in   : system clock, rising edge
//   rst      : asynchronous, active-high reset
//   en       : run enable; low holds the channel idle with outputs at 0
//   restart  : one-cycle phase restart, wins over en
//   load     : write strobe for this channel's shadow config
//   cfg_div  : new period in clk_in cycles
//   cfg_high : new high time in clk_in cycles
//   pending  : shadow written but not yet applied
//   clk_out  : registered divided clock
//   tick     : one-cycle pulse at the start of each period
// Active config only changes on a period boundary or while the channel is
// idle, so a running output never sees a partial period.
module freq_div_chan
  import freq_div_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int DEFAULT_DIV  = DEF_DIV,
  parameter int DEFAULT_HIGH = DEF_HIGH
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic             load,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_high,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] act_div;
  logic [WIDTH-1:0] act_high;
  logic [WIDTH-1:0] sh_div;
  logic [WIDTH-1:0] sh_high;
  logic [WIDTH-1:0] peff;
  logic [WIDTH-1:0] heff;
  eff_t             eff;
  logic             running;
  logic             last;
  logic             apply;
  logic             unused_hi;

  // NOTE: every signal written here is assigned on every path through the
  // block, so no latch can be inferred.
  always_comb begin
    eff  = saturate(calc_t'(act_div), calc_t'(act_high));
    peff = eff.div[WIDTH-1:0];
    heff = eff.high[WIDTH-1:0];
  end

  // Upper bits are zero by construction (inputs were zero-extended).
  assign unused_hi = ^{eff.div[CALC_W-1:WIDTH], eff.high[CALC_W-1:WIDTH]};

  assign running = en & ~restart;
  // cnt never exceeds peff-1, so equality marks the terminal count.
  assign last    = (cnt == peff - WIDTH'(1));
  // Idle channels take a pending shadow on the very next edge.
  assign apply   = pending & (~running | last);

  // NOTE: the config registers are reset along with the counter, so a reset
  // discards any programmed value and restores the defaults.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      pending  <= 1'b0;
      act_div  <= WIDTH'(DEFAULT_DIV);
      act_high <= WIDTH'(DEFAULT_HIGH);
      sh_div   <= WIDTH'(DEFAULT_DIV);
      sh_high  <= WIDTH'(DEFAULT_HIGH);
    end else begin
      // NOTE: non-blocking assignments make every register sample pre-edge
      // values; a load landing on a boundary edge therefore applies the old
      // shadow while capturing the new one.
      if (running) begin
        cnt     <= last ? '0 : cnt + WIDTH'(1);
        clk_out <= (cnt < heff);
        tick    <= (cnt == '0);
      end else begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end

      if (apply) begin
        act_div  <= sh_div;
        act_high <= sh_high;
      end

      if (load) begin
        sh_div  <= cfg_div;
        sh_high <= cfg_high;
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/freq_div_multi.sv
// freq_div_multi: NCH independent runtime-programmable clock dividers.
//   clk_in      : system clock, rising edge
//   rst         : asynchronous, active-high reset
//   en          : per-channel run enable
//   restart     : per-channel one-cycle phase restart
//   cfg_load    : shadow config write strobe
//   cfg_ch      : channel addressed by cfg_load (values >= NCH are ignored)
//   cfg_div     : new period in clk_in cycles
//   cfg_high    : new high time in clk_in cycles
//   cfg_pending : per-channel shadow written, not yet applied
//   clk_out     : per-channel registered divided clock
//   tick        : per-channel one-cycle pulse at each period start
// All outputs come straight from channel registers.
module freq_div_multi
  import freq_div_pkg::*;
#(
  parameter  int NCH          = 4,
  parameter  int WIDTH        = 16,
  parameter  int DEFAULT_DIV  = DEF_DIV,
  parameter  int DEFAULT_HIGH = DEF_HIGH,
  localparam int CHW          = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic [NCH-1:0]   restart,
  input  logic             cfg_load,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_high,
  output logic [NCH-1:0]   cfg_pending,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic load;

    // Exact match against the channel index: an out-of-range cfg_ch
    // selects no channel and the write is dropped.
    assign load = cfg_load && (int'(cfg_ch) == i);

    freq_div_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV),
      .DEFAULT_HIGH(DEFAULT_HIGH)
    ) u_chan (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (en[i]),
      .restart (restart[i]),
      .load    (load),
      .cfg_div (cfg_div),
      .cfg_high(cfg_high),
      .pending (cfg_pending[i]),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end

endmodule

// File: tb/tb_freq_div_multi.sv
// tb_freq_div_multi: directed self-checking bench for freq_div_multi.
// Main instance has NCH=4; a second NCH=3 instance exercises an
// out-of-range cfg_ch that a 2-bit select can still encode.
module tb_freq_div_multi;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic [3:0]  restart;
  logic        cfg_load;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic [15:0] cfg_high;
  logic [3:0]  cfg_pending;
  logic [3:0]  clk_out;
  logic [3:0]  tick;

  logic [2:0]  en_s;
  logic [2:0]  restart_s;
  logic        cfg_load_s;
  logic [1:0]  cfg_ch_s;
  logic [2:0]  pend_s;
  logic [2:0]  clk_s;
  logic [2:0]  tick_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  freq_div_multi u_dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .en         (en),
    .restart    (restart),
    .cfg_load   (cfg_load),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_high   (cfg_high),
    .cfg_pending(cfg_pending),
    .clk_out    (clk_out),
    .tick       (tick)
  );

  freq_div_multi #(.NCH(3)) u_dut_small (
    .clk_in     (clk_in),
    .rst        (rst),
    .en         (en_s),
    .restart    (restart_s),
    .cfg_load   (cfg_load_s),
    .cfg_ch     (cfg_ch_s),
    .cfg_div    (cfg_div),
    .cfg_high   (cfg_high),
    .cfg_pending(pend_s),
    .clk_out    (clk_s),
    .tick       (tick_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit later. Strobes are
  // single-cycle, so they are dropped right after the edge.
  task automatic step();
    @(posedge clk_in);
    #1;
    cfg_load   = 1'b0;
    cfg_load_s = 1'b0;
    restart    = '0;
  endtask

  task automatic drive_load(input int ch, input int div, input int high);
    cfg_load = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_div  = 16'(div);
    cfg_high = 16'(high);
  endtask

  // Runs n edges; bit i of cp/tp is the expected clk_out/tick after edge i.
  task automatic run_pat(input int ch, input int n, input logic [31:0] cp,
                         input logic [31:0] tp, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      check($sformatf("%s.clk[%0d]", tag, i), 32'(clk_out[ch]), 32'(cp[i]));
      check($sformatf("%s.tick[%0d]", tag, i), 32'(tick[ch]), 32'(tp[i]));
    end
  endtask

  // Programs an idle channel: load edge, then the apply edge.
  task automatic prog(input int ch, input int div, input int high, input string tag);
    en[ch] = 1'b0;
    drive_load(ch, div, high);
    step();
    step();
    check({tag, ".pend"}, 32'(cfg_pending[ch]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    en         = '0;
    restart    = '0;
    cfg_load   = 1'b0;
    cfg_ch     = '0;
    cfg_div    = '0;
    cfg_high   = '0;
    en_s       = '0;
    restart_s  = '0;
    cfg_load_s = 1'b0;
    cfg_ch_s   = '0;

    // Reset state
    repeat (2) @(posedge clk_in);
    #1;
    check("rst.clk", 32'(clk_out), 32'd0);
    check("rst.tick", 32'(tick), 32'd0);
    check("rst.pend", 32'(cfg_pending), 32'd0);
    check("rst.small", 32'({pend_s, clk_s, tick_s}), 32'd0);
    rst = 1'b0;

    // Defaults on ch0: 4/2
    en[0] = 1'b1;
    run_pat(0, 8, 32'b00110011, 32'b00010001, "t1.def");
    en[0] = 1'b0;

    // ch1: program 5/2 while idle, then reprogram 3/1 mid-period
    drive_load(1, 5, 2);
    run_pat(1, 1, 32'b0, 32'b0, "t2.ld");
    check("t2.pend_set", 32'(cfg_pending[1]), 32'd1);
    run_pat(1, 1, 32'b0, 32'b0, "t2.idle");
    check("t2.pend_idle", 32'(cfg_pending[1]), 32'd0);
    en[1] = 1'b1;
    run_pat(1, 6, 32'b100011, 32'b100001, "t2.p5");
    drive_load(1, 3, 1);
    run_pat(1, 1, 32'b1, 32'b0, "t2.mid");
    check("t2.pend_c1", 32'(cfg_pending[1]), 32'd1);
    run_pat(1, 1, 32'b0, 32'b0, "t2.c2");
    check("t2.pend_c2", 32'(cfg_pending[1]), 32'd1);
    run_pat(1, 1, 32'b0, 32'b0, "t2.c3");
    check("t2.pend_c3", 32'(cfg_pending[1]), 32'd1);
    run_pat(1, 1, 32'b0, 32'b0, "t2.bnd");
    check("t2.pend_clr", 32'(cfg_pending[1]), 32'd0);
    run_pat(1, 6, 32'b001001, 32'b001001, "t2.p3");
    en[1] = 1'b0;

    // ch2: odd and saturating values
    prog(2, 7, 4, "t3.a");
    en[2] = 1'b1;
    run_pat(2, 14, 32'b00011110001111, 32'b00000010000001, "t3.d7h4");
    prog(2, 7, 0, "t3.b");
    en[2] = 1'b1;
    run_pat(2, 14, 32'b0, 32'b00000010000001, "t3.d7h0");
    prog(2, 7, 9, "t3.c");
    en[2] = 1'b1;
    run_pat(2, 14, 32'h3FFF, 32'b00000010000001, "t3.d7h9");
    prog(2, 0, 0, "t3.d");
    en[2] = 1'b1;
    run_pat(2, 4, 32'b0, 32'b1111, "t3.d0h0");
    prog(2, 0, 3, "t3.e");
    en[2] = 1'b1;
    run_pat(2, 3, 32'b111, 32'b111, "t3.d0h3");
    en[2] = 1'b0;

    // ch3: load on the boundary edge, then last-write-wins
    en[3] = 1'b1;
    run_pat(3, 4, 32'b0011, 32'b0001, "t4.p0");
    drive_load(3, 3, 1);
    run_pat(3, 1, 32'b1, 32'b1, "t4.ldA");
    check("t4.pendA", 32'(cfg_pending[3]), 32'd1);
    run_pat(3, 2, 32'b01, 32'b00, "t4.p1");
    drive_load(3, 5, 3);
    run_pat(3, 1, 32'b0, 32'b0, "t4.bnd");
    check("t4.pend_bnd", 32'(cfg_pending[3]), 32'd1);
    run_pat(3, 2, 32'b01, 32'b01, "t4.p3");
    check("t4.pendB", 32'(cfg_pending[3]), 32'd1);
    run_pat(3, 1, 32'b0, 32'b0, "t4.bnd2");
    check("t4.pend_clr", 32'(cfg_pending[3]), 32'd0);
    run_pat(3, 5, 32'b00111, 32'b00001, "t4.p5");
    drive_load(3, 2, 1);
    run_pat(3, 1, 32'b1, 32'b1, "t4.ld1");
    drive_load(3, 6, 2);
    run_pat(3, 1, 32'b1, 32'b0, "t4.ld2");
    run_pat(3, 3, 32'b001, 32'b000, "t4.tail");
    check("t4.pend_lww", 32'(cfg_pending[3]), 32'd0);
    run_pat(3, 6, 32'b000011, 32'b000001, "t4.p6");
    en[3] = 1'b0;

    // Out-of-range channel on the NCH=3 instance
    cfg_div    = 16'd2;
    cfg_high   = 16'd1;
    cfg_load_s = 1'b1;
    cfg_ch_s   = 2'd3;
    step();
    check("t5.oor_pend", 32'(pend_s), 32'd0);
    cfg_load_s = 1'b1;
    cfg_ch_s   = 2'd2;
    step();
    check("t5.ch2_pend", 32'(pend_s), 32'b100);

    // Phase alignment by restart
    for (int c = 0; c < 4; c++) prog(c, 6, 3, $sformatf("t6.prog%0d", c));
    for (int c = 0; c < 4; c++) begin
      en[c] = 1'b1;
      step();
    end
    step();
    restart = 4'hF;
    step();
    check("t6.rs_clk", 32'(clk_out), 32'd0);
    check("t6.rs_tick", 32'(tick), 32'd0);
    for (int k = 0; k < 12; k++) begin
      step();
      check($sformatf("t6.clk[%0d]", k), 32'(clk_out), ((k % 6) < 3) ? 32'hF : 32'h0);
      check($sformatf("t6.tick[%0d]", k), 32'(tick), ((k % 6) == 0) ? 32'hF : 32'h0);
    end

    // Asynchronous reset mid-period
    en = 4'b0001;
    drive_load(0, 9, 9);
    step();
    check("t7.pre_clk", 32'(clk_out[0]), 32'd1);
    check("t7.pre_pend", 32'(cfg_pending[0]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t7.async_clk", 32'(clk_out), 32'd0);
    check("t7.async_tick", 32'(tick), 32'd0);
    check("t7.async_pend", 32'(cfg_pending), 32'd0);
    @(posedge clk_in);
    #1;
    rst = 1'b0;
    run_pat(0, 8, 32'b00110011, 32'b00010001, "t7.def");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
